// File: rtl/qeip_axi_burst_initiator_pkg.sv
// Shared types and constants for the single-burst AXI initiator.
// The state encoding, AXI field encodings and the size/response helpers live here.
package qeip_axi_burst_initiator_pkg;

    localparam int BW_AXI_ALEN  = 8;
    localparam int BW_AXI_BRESP = 2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } state_e;

    // AXI size field: log2 of bytes per beat.
    function automatic logic [2:0] axi_size(input int bw_data);
        return 3'($clog2(bw_data / 8));
    endfunction

    // Response severity follows the numeric encoding, so SLVERR/DECERR stick once seen.
    function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qeip_axi_burst_initiator_beat_counter.sv
// Counts accepted data beats of the current burst and flags the beat whose index equals len.
module qeip_axi_burst_initiator_beat_counter #(
    parameter int BW_CNT = 8
) (
    input  logic              clk_i,
    input  logic              rstnn_i,
    input  logic              clear_i,
    input  logic              inc_i,
    input  logic [BW_CNT-1:0] len_i,
    output logic [BW_CNT-1:0] count_o,
    output logic              last_o
);

    logic [BW_CNT-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == len_i);

endmodule

// File: rtl/qeip_axi_burst_initiator.sv
// Turns one read/write command into a single INCR burst on an AXI master port, streams
// the data beats through valid/ready ports and pulses done with the worst response seen.
module qeip_axi_burst_initiator
    import qeip_axi_burst_initiator_pkg::*;
#(
    parameter int                    BW_ADDR    = 32,
    parameter int                    BW_DATA    = 32,
    parameter int                    BW_AXI_TID = 4,
    parameter logic [BW_AXI_TID-1:0] TID        = '0
) (
    input  logic                    clk_i,
    input  logic                    rstnn_i,
    // command port
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [BW_ADDR-1:0]      cmd_addr_i,
    input  logic [BW_AXI_ALEN-1:0]  cmd_len_i,
    // write-data stream
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [BW_DATA-1:0]      wr_data_i,
    // read-data stream
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [BW_DATA-1:0]      rd_data_o,
    output logic                    rd_last_o,
    // completion
    output logic                    done_valid_o,
    output logic [BW_AXI_BRESP-1:0] done_resp_o,
    // AXI write address
    output logic [BW_AXI_TID-1:0]   awid_o,
    output logic [BW_ADDR-1:0]      awaddr_o,
    output logic [BW_AXI_ALEN-1:0]  awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    // AXI write data
    output logic [BW_AXI_TID-1:0]   wid_o,
    output logic [BW_DATA-1:0]      wdata_o,
    output logic [BW_DATA/8-1:0]    wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    // AXI write response
    input  logic [BW_AXI_TID-1:0]   bid_i,
    input  logic [BW_AXI_BRESP-1:0] bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    // AXI read address
    output logic [BW_AXI_TID-1:0]   arid_o,
    output logic [BW_ADDR-1:0]      araddr_o,
    output logic [BW_AXI_ALEN-1:0]  arlen_o,
    output logic [2:0]              arsize_o,
    output logic [1:0]              arburst_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    // AXI read data
    input  logic [BW_AXI_TID-1:0]   rid_i,
    input  logic [BW_DATA-1:0]      rdata_i,
    input  logic [BW_AXI_BRESP-1:0] rresp_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    // debug
    output state_e                  state_o
);

    localparam int         ADDR_LSB = $clog2(BW_DATA / 8);
    localparam logic [2:0] AXI_SIZE = axi_size(BW_DATA);

    state_e                  state_q;
    logic [BW_ADDR-1:0]      addr_q;
    logic [BW_AXI_ALEN-1:0]  len_q;
    logic                    awvalid_q;
    logic                    arvalid_q;
    logic                    done_valid_q;
    logic [BW_AXI_BRESP-1:0] resp_q;

    logic                    in_w;
    logic                    in_r;
    logic                    w_fire;
    logic                    r_fire;
    logic                    cnt_clear;
    logic                    cnt_last;
    logic [BW_AXI_ALEN-1:0]  cnt_value;

    // IDs are constant and only one burst is outstanding, so returned IDs carry no information.
    logic unused_id;
    assign unused_id = ^{bid_i, rid_i, cnt_value};

    assign in_w      = (state_q == ST_W);
    assign in_r      = (state_q == ST_R);
    assign w_fire    = in_w & wr_valid_i & wready_i;
    assign r_fire    = in_r & rvalid_i & rd_ready_i;
    assign cnt_clear = ((state_q == ST_AW) & awready_i) | ((state_q == ST_AR) & arready_i);

    qeip_axi_burst_initiator_beat_counter #(
        .BW_CNT (BW_AXI_ALEN)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rstnn_i (rstnn_i),
        .clear_i (cnt_clear),
        .inc_i   (w_fire | r_fire),
        .len_i   (len_q),
        .count_o (cnt_value),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            done_valid_q <= 1'b0;
            resp_q       <= AXI_RESP_OKAY;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q <= (cmd_addr_i >> ADDR_LSB) << ADDR_LSB;
                        len_q  <= cmd_len_i;
                        resp_q <= AXI_RESP_OKAY;
                        if (cmd_write_i) begin
                            state_q   <= ST_AW;
                            awvalid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire && cnt_last) begin
                        state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid_i) begin
                        resp_q       <= worse_resp(resp_q, bresp_i);
                        done_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    // A burst the slave cuts short is reported as at least SLVERR.
                    if (r_fire) begin
                        resp_q <= worse_resp(worse_resp(resp_q, rresp_i),
                                             (rlast_i && !cnt_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
                        if (rlast_i) begin
                            done_valid_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign done_valid_o = done_valid_q;
    assign done_resp_o  = resp_q;
    assign state_o      = state_q;

    assign awid_o    = TID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_q;
    assign awsize_o  = AXI_SIZE;
    assign awburst_o = AXI_BURST_INCR;
    assign awvalid_o = awvalid_q;

    assign wid_o      = TID;
    assign wdata_o    = wr_data_i;
    assign wstrb_o    = '1;
    assign wlast_o    = in_w & cnt_last;
    assign wvalid_o   = in_w & wr_valid_i;
    assign wr_ready_o = in_w & wready_i;

    assign bready_o = (state_q == ST_B);

    assign arid_o    = TID;
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = AXI_SIZE;
    assign arburst_o = AXI_BURST_INCR;
    assign arvalid_o = arvalid_q;

    assign rd_valid_o = in_r & rvalid_i;
    assign rready_o   = in_r & rd_ready_i;
    assign rd_data_o  = rdata_i;
    assign rd_last_o  = rlast_i;

endmodule

// File: tb/tb_qeip_axi_burst_initiator.sv
// Directed bench for the burst initiator: an SRAM-like AXI slave, a transaction-level
// expectation model with one per-cycle compare process, and literal spot checks.
`timescale 1ns/1ps
module tb_qeip_axi_burst_initiator;
    import qeip_axi_burst_initiator_pkg::*;

    localparam int               IW     = 4;
    localparam logic [IW-1:0]    TB_TID = 4'h5;

    logic clk = 1'b0;
    logic rstnn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [31:0] rd_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [IW-1:0] awid, wid, arid;
    logic [IW-1:0] bid = '0, rid = '0;
    logic [31:0] awaddr, araddr, wdata;
    logic [31:0] rdata = '0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b1;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b1;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    state_e      dbg_state;

    qeip_axi_burst_initiator #(
        .BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(IW), .TID(TB_TID)
    ) dut (
        .clk_i(clk), .rstnn_i(rstnn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
        .done_valid_o(done_valid), .done_resp_o(done_resp),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
        .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
        .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
        .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
        .rvalid_i(rvalid), .rready_o(rready),
        .state_o(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    logic [39:0] exp_aw_q[$];
    logic [39:0] exp_ar_q[$];
    logic [32:0] exp_w_q[$];
    logic [32:0] exp_r_q[$];
    logic [1:0]  exp_done_q[$];
    logic [31:0] ref_mem[logic [31:0]];

    task automatic expect_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
        logic [31:0] a;
        a = addr & ~32'h3;
        exp_aw_q.push_back({a, len});
        for (int i = 0; i <= int'(len); i++) begin
            exp_w_q.push_back({base + 32'(i), (i == int'(len))});
            ref_mem[a + 32'(4 * i)] = base + 32'(i);
        end
        exp_done_q.push_back(AXI_RESP_OKAY);
    endtask

    task automatic expect_read(input logic [31:0] addr, input logic [7:0] len,
                               input int err_beat, input int last_beat);
        logic [31:0] a, d;
        logic [1:0]  resp;
        int          n;
        a    = addr & ~32'h3;
        n    = (last_beat >= 0 && last_beat < int'(len)) ? last_beat + 1 : int'(len) + 1;
        resp = AXI_RESP_OKAY;
        for (int i = 0; i < n; i++) begin
            d = ref_mem.exists(a + 32'(4 * i)) ? ref_mem[a + 32'(4 * i)] : 32'h0;
            exp_r_q.push_back({d, (i == n - 1)});
            if (i == err_beat) resp = AXI_RESP_SLVERR;
        end
        if (n < int'(len) + 1) resp = AXI_RESP_SLVERR;
        exp_ar_q.push_back({a, len});
        exp_done_q.push_back(resp);
    endtask

    // ---------------- AXI SRAM slave model ----------------
    logic [31:0] smem[logic [31:0]];
    int          aw_stall_cfg = 0;
    int          rerr_beat_cfg = -1;
    int          rlast_beat_cfg = -1;
    logic [31:0] s_wptr = '0, s_rptr = '0;
    int          s_rbeat = 0, s_rlen = 0, s_aw_wait = 0;

    task automatic slave_present();
        rvalid = 1'b1;
        rdata  = smem.exists(s_rptr) ? smem[s_rptr] : 32'h0;
        rresp  = (s_rbeat == rerr_beat_cfg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast  = (s_rbeat == s_rlen) || (s_rbeat == rlast_beat_cfg);
    endtask

    initial begin : slave
        logic        s_rst, aw_hs, aw_pend, w_hs, b_hs, ar_hs, r_hs, c_wlast, c_rlast;
        logic [31:0] c_awaddr, c_araddr, c_wdata;
        logic [7:0]  c_arlen;
        forever begin
            @(negedge clk);
            s_rst    = !rstnn;
            aw_hs    = awvalid && awready;
            aw_pend  = awvalid && !awready;
            w_hs     = wvalid && wready;
            b_hs     = bvalid && bready;
            ar_hs    = arvalid && arready;
            r_hs     = rvalid && rready;
            c_awaddr = awaddr;
            c_araddr = araddr;
            c_arlen  = arlen;
            c_wdata  = wdata;
            c_wlast  = wlast;
            c_rlast  = rlast;
            @(posedge clk);
            #1;
            if (s_rst) begin
                bvalid    = 1'b0;
                rvalid    = 1'b0;
                rlast     = 1'b0;
                s_aw_wait = 0;
                awready   = (0 >= aw_stall_cfg);
            end else begin
                if (aw_hs) begin
                    s_wptr    = c_awaddr;
                    s_aw_wait = 0;
                end else if (aw_pend) begin
                    s_aw_wait++;
                end
                awready = (s_aw_wait >= aw_stall_cfg);
                if (w_hs) begin
                    smem[s_wptr] = c_wdata;
                    s_wptr       = s_wptr + 32'd4;
                    if (c_wlast) begin
                        bvalid = 1'b1;
                        bresp  = AXI_RESP_OKAY;
                    end
                end
                if (b_hs) bvalid = 1'b0;
                if (ar_hs) begin
                    s_rptr  = c_araddr;
                    s_rbeat = 0;
                    s_rlen  = int'(c_arlen);
                    slave_present();
                end else if (r_hs) begin
                    if (c_rlast) begin
                        rvalid = 1'b0;
                        rlast  = 1'b0;
                    end else begin
                        s_rbeat++;
                        s_rptr = s_rptr + 32'd4;
                        slave_present();
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   aw_stall_seen = 0;
    int   rd_beats = 0;
    logic [1:0] last_done_resp = '0;

    initial begin : compare
        logic busy, aw_seen, done_due, aw_due, ar_due;
        busy = 1'b0; aw_seen = 1'b0; done_due = 1'b0; aw_due = 1'b0; ar_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstnn) begin
                exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
                exp_r_q.delete(); exp_done_q.delete();
                busy = 1'b0; aw_seen = 1'b0; done_due = 1'b0; aw_due = 1'b0; ar_due = 1'b0;
            end else begin
                check("cmd_ready", cmd_ready, !busy);
                check("done_valid", done_valid, done_due);
                if (done_valid && exp_done_q.size() > 0) begin
                    check("done_resp", done_resp, exp_done_q.pop_front());
                    last_done_resp = done_resp;
                end
                if (aw_due) check("awvalid_latency", awvalid, 1'b1);
                if (ar_due) check("arvalid_latency", arvalid, 1'b1);
                if (awvalid && !awready) aw_stall_seen++;
                if (awvalid && awready) begin
                    if (exp_aw_q.size() > 0)
                        check("aw", {awaddr, awlen, awsize, awburst, awid},
                              {exp_aw_q.pop_front(), 3'd2, AXI_BURST_INCR, TB_TID});
                    else
                        check("aw_unexpected", awvalid, 1'b0);
                    aw_seen = 1'b1;
                end
                if (wvalid && !aw_seen) check("w_before_aw", wvalid, 1'b0);
                if (wvalid && wready) begin
                    if (exp_w_q.size() > 0)
                        check("w_beat", {wdata, wlast, wstrb, wid}, {exp_w_q.pop_front(), 4'hF, TB_TID});
                    else
                        check("w_unexpected", wvalid, 1'b0);
                end
                if (bvalid) check("bready", bready, 1'b1);
                if (arvalid && arready) begin
                    if (exp_ar_q.size() > 0)
                        check("ar", {araddr, arlen, arsize, arburst, arid},
                              {exp_ar_q.pop_front(), 3'd2, AXI_BURST_INCR, TB_TID});
                    else
                        check("ar_unexpected", arvalid, 1'b0);
                end
                if (rvalid) check("rd_pass", {rd_valid, rready}, {1'b1, rd_ready});
                if (rd_valid && rd_ready) begin
                    rd_beats++;
                    if (exp_r_q.size() > 0)
                        check("rd_beat", {rd_data, rd_last}, exp_r_q.pop_front());
                    else
                        check("rd_unexpected", rd_valid, 1'b0);
                end
                done_due = (bvalid && bready) || (rvalid && rready && rlast);
                if (done_due) begin
                    busy    = 1'b0;
                    aw_seen = 1'b0;
                end
                aw_due = cmd_valid && cmd_ready && cmd_write;
                ar_due = cmd_valid && cmd_ready && !cmd_write;
                if (cmd_valid && cmd_ready) busy = 1'b1;
            end
        end
    end

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                            output logic in_done);
        logic acc, dn;
        in_done   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = cmd_ready;
            dn  = done_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                in_done   = dn;
                cmd_valid = 1'b0;
                return;
            end
        end
        check("cmd_accept_timeout", cmd_ready, 1'b1);
        cmd_valid = 1'b0;
    endtask

    task automatic stream_write(input logic [31:0] base, input logic [7:0] len);
        int   i;
        logic hs;
        i        = 0;
        wr_valid = 1'b1;
        wr_data  = base;
        for (int c = 0; c < 200 && i <= int'(len); c++) begin
            @(negedge clk);
            hs = wr_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                i++;
                wr_data = base + 32'(i);
            end
        end
        wr_valid = 1'b0;
        if (i <= int'(len)) check("wr_stream_timeout", i, int'(len) + 1);
    endtask

    task automatic wait_done();
        logic found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            found = done_valid;
            @(posedge clk);
            #1;
            if (found) return;
        end
        check("done_timeout", done_valid, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
        logic dn;
        expect_write(addr, len, base);
        fork
            send_cmd(1'b1, addr, len, dn);
            stream_write(base, len);
        join
        wait_done();
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic toggle);
        logic dn, stop;
        stop = 1'b0;
        expect_read(addr, len, rerr_beat_cfg, rlast_beat_cfg);
        rd_ready = 1'b1;
        fork
            begin
                send_cmd(1'b0, addr, len, dn);
                wait_done();
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    if (toggle && !stop) rd_ready = !rd_ready;
                end
            end
        join
        rd_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic dn1, dn2;
        rstnn = 1'b0;
        idle(3);
        check("rst_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rd_valid, done_valid},
              7'b1000000);
        check("rst_regs", {awaddr, awlen, done_resp}, {32'h0, 8'h0, AXI_RESP_OKAY});
        rstnn = 1'b1;
        idle(2);

        // 4-beat write, then the slave memory must hold the beats
        run_write(32'h100, 8'd3, 32'hA0);
        idle(2);
        for (int i = 0; i < 4; i++)
            check("sram_content", smem.exists(32'h100 + 32'(4 * i)) ? smem[32'h100 + 32'(4 * i)] : 32'hDEAD,
                  32'hA0 + 32'(i));

        // 4-beat read with rd_ready toggling
        rd_beats = 0;
        run_read(32'h100, 8'd3, 1'b1);
        check("toggle_read_beats", rd_beats, 4);
        idle(2);

        // single beat write while AW is held off
        aw_stall_cfg  = 5;
        idle(2);
        aw_stall_seen = 0;
        run_write(32'h0, 8'd0, 32'hE0);
        check("aw_stall_cycles", aw_stall_seen, 5);
        aw_stall_cfg = 0;
        idle(2);
        check("sram_single", smem.exists(32'h0) ? smem[32'h0] : 32'hDEAD, 32'hE0);

        // error response on the first of two beats, unaligned start address
        rerr_beat_cfg = 0;
        rd_beats = 0;
        run_read(32'h106, 8'd1, 1'b0);
        rerr_beat_cfg = -1;
        check("slverr_beats", rd_beats, 2);
        check("slverr_resp", last_done_resp, AXI_RESP_SLVERR);
        idle(2);

        // slave ends a 4-beat read after 2 beats
        rlast_beat_cfg = 1;
        rd_beats = 0;
        run_read(32'h100, 8'd3, 1'b0);
        rlast_beat_cfg = -1;
        check("early_rlast_beats", rd_beats, 2);
        check("early_rlast_resp", last_done_resp, AXI_RESP_SLVERR);
        idle(2);

        // reset during the second W beat of an 8-beat write
        expect_write(32'h200, 8'd7, 32'hB0);
        fork
            send_cmd(1'b1, 32'h200, 8'd7, dn1);
            begin : first_beat
                logic hs;
                wr_valid = 1'b1;
                wr_data  = 32'hB0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    hs = wr_ready;
                    @(posedge clk);
                    #1;
                    if (hs) begin
                        wr_data = 32'hB1;
                        break;
                    end
                end
            end
        join
        rstnn = 1'b0;
        @(negedge clk);
        check("mid_burst_wvalid", wvalid, 1'b1);
        @(posedge clk);
        #1;
        check("post_reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rd_valid, done_valid},
              7'b1000000);
        rstnn    = 1'b1;
        wr_valid = 1'b0;
        idle(2);
        run_write(32'h200, 8'd7, 32'hD0);
        idle(1);
        run_read(32'h200, 8'd7, 1'b0);
        idle(2);

        // back-to-back: read queued behind a write on a held cmd_valid
        expect_write(32'h300, 8'd1, 32'hC0);
        expect_read(32'h300, 8'd1, -1, -1);
        rd_ready = 1'b1;
        fork
            begin
                send_cmd(1'b1, 32'h300, 8'd1, dn1);
                send_cmd(1'b0, 32'h300, 8'd1, dn2);
            end
            stream_write(32'hC0, 8'd1);
        join
        check("b2b_accept_in_done_cycle", dn2, 1'b1);
        wait_done();
        rd_ready = 1'b0;
        idle(3);

        check("exp_queues_drained",
              exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_r_q.size() + exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
